// File: rtl/jtag_byte_master_if.sv
// ----------------------------------------------------------------------------
// jtag_byte_master_if
//   Signal bundle between a byte-serial JTAG host master and its user/target.
//
//   Byte handshake (valid/ready): a byte is transferred on a rising clock edge
//   where iTx_Valid and oTx_Ready are both high. iTx_Data must be stable in
//   that cycle. oRx_Valid is a one-cycle pulse marking oRx_Data as fresh; it
//   has no ready and cannot be back-pressured.
//
//   Signals:
//     iTx_Data  [7:0]  byte to send on TDI
//     iTx_Valid        send request
//     oTx_Ready        master idle, can accept a byte
//     oRx_Data  [7:0]  byte captured from TDO
//     oRx_Valid        one-cycle receive strobe
//     oBusy            frame in progress
//     TCK/TCS/TDI      JTAG wires driven by the master
//     TDO              JTAG wire driven by the target
//
//   Modports: master = the jtag_byte_master side, slave = user/target side.
// ----------------------------------------------------------------------------
interface jtag_byte_master_if;
    logic [7:0] iTx_Data;
    logic       iTx_Valid;
    logic       oTx_Ready;
    logic [7:0] oRx_Data;
    logic       oRx_Valid;
    logic       oBusy;
    logic       TCK;
    logic       TCS;
    logic       TDI;
    logic       TDO;

    modport master (
        input  iTx_Data, iTx_Valid, TDO,
        output oTx_Ready, oRx_Data, oRx_Valid, oBusy, TCK, TCS, TDI
    );

    modport slave (
        output iTx_Data, iTx_Valid, TDO,
        input  oTx_Ready, oRx_Data, oRx_Valid, oBusy, TCK, TCS, TDI
    );
endinterface

// File: rtl/jtag_byte_master.sv
// ----------------------------------------------------------------------------
// jtag_byte_master
//   Host-side initiator of the byte-serial JTAG link. Each accepted byte is
//   sent LSB first on TDI over one TCS-low frame of 8 TCK pulses; the byte
//   returned by the target on TDO is captured in the same frame.
//
//   Parameters:
//     CLK_DIV     iCLK cycles per TCK half-period (>= 1)
//
//   Ports:
//     iCLK        system clock, rising edge
//     iRST        synchronous active-high reset
//     bus         jtag_byte_master_if.master (byte handshake + JTAG wires)
//     oDbg_State  current FSM state encoding, for observation only
//
//   Frame timing for an accept in cycle T (C = CLK_DIV):
//     T+1            TCS low, TDI = bit0
//     T+1+C*(1+2k)   TCK rise k
//     T+1+C*(2+2k)   TCK fall k: TDO shifted in as bit k, TDI -> bit k+1
//     T+1+18C        TCS high, oRx_Valid pulse
//     T+1+19C        oTx_Ready high again
// ----------------------------------------------------------------------------
module jtag_byte_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    jtag_byte_master_if.master    bus,
    output logic [2:0]            oDbg_State
);

    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    // Only reachable when CLK_DIV >= 2; GAP is skipped entirely for CLK_DIV=1.
    localparam logic [DW-1:0] GAP_LAST = DW'(CLK_DIV - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_div;
    logic [2:0]      r_bit;
    logic [7:0]      r_tx_sh;
    logic [7:0]      r_rx_sh;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_ready;
    logic            r_busy;
    logic            r_tck;
    logic            r_tcs;
    logic            r_tdi;

    state_t          w_next;
    logic            w_div_done;
    logic            w_accept;
    logic            w_fall;
    logic            w_bit_adv;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_div_done = (r_div == DIV_LAST);
        w_accept   = 1'b0;
        w_fall     = 1'b0;
        w_bit_adv  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.iTx_Valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SETUP;
                end
            end
            S_SETUP: if (w_div_done) w_next = S_HIGH;
            S_HIGH: begin
                if (w_div_done) begin
                    w_fall = 1'b1;
                    w_next = S_LOW;
                end
            end
            S_LOW: begin
                if (w_div_done) begin
                    if (r_bit == 3'd7) begin
                        w_next = S_HOLD;
                    end else begin
                        w_bit_adv = 1'b1;
                        w_next    = S_HIGH;
                    end
                end
            end
            S_HOLD: if (w_div_done) w_next = S_DONE;
            S_DONE: w_next = (CLK_DIV == 1) ? S_IDLE : S_GAP;
            S_GAP:  if (r_div == GAP_LAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_tck      <= 1'b0;
            r_tcs      <= 1'b1;
            r_tdi      <= 1'b0;
        end else begin
            r_state <= w_next;
            // Divider restarts on every state change and rests at 0 in IDLE.
            if ((w_next != r_state) || (w_next == S_IDLE))
                r_div <= '0;
            else
                r_div <= r_div + DW'(1);

            // Outputs are a function of the state being entered, so they
            // change on the same edge as the state register.
            r_tck      <= (w_next == S_HIGH);
            r_tcs      <= (w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_GAP);
            r_ready    <= (w_next == S_IDLE);
            r_busy     <= (w_next != S_IDLE);
            r_rx_valid <= (w_next == S_DONE);

            if (w_accept) begin
                r_tx_sh <= bus.iTx_Data;
                r_tdi   <= bus.iTx_Data[0];
                r_bit   <= '0;
            end

            // Falling TCK: the target updated TDO on the rising edge, so it
            // has been stable for the whole HIGH phase.
            if (w_fall) begin
                r_tx_sh <= {1'b0, r_tx_sh[7:1]};
                r_tdi   <= r_tx_sh[1];
                r_rx_sh <= {bus.TDO, r_rx_sh[7:1]};
            end

            if (w_bit_adv)
                r_bit <= r_bit + 3'd1;

            if ((w_next == S_DONE) && (r_state != S_DONE))
                r_rx_data <= r_rx_sh;
        end
    end

    assign bus.oTx_Ready = r_ready;
    assign bus.oBusy     = r_busy;
    assign bus.oRx_Data  = r_rx_data;
    assign bus.oRx_Valid = r_rx_valid;
    assign bus.TCK       = r_tck;
    assign bus.TCS       = r_tcs;
    assign bus.TDI       = r_tdi;
    assign oDbg_State    = r_state;

endmodule

// File: tb/tb_jtag_byte_master.sv
// ----------------------------------------------------------------------------
// tb_jtag_byte_master
//   Two masters (CLK_DIV=4 and CLK_DIV=1) on one clock. A negedge monitor
//   records JTAG edges and strobes with cycle stamps and plays a simple target
//   that drives the next response bit on TDO at each TCK rise. Expected
//   timing comes from the frame formulas in terms of the accept cycle T.
// ----------------------------------------------------------------------------
module tb_jtag_byte_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg4, dbg1;

    jtag_byte_master_if bus4();
    jtag_byte_master_if bus1();

    jtag_byte_master #(.CLK_DIV(4)) u_dut4 (.iCLK(clk), .iRST(rst), .bus(bus4), .oDbg_State(dbg4));
    jtag_byte_master #(.CLK_DIV(1)) u_dut1 (.iCLK(clk), .iRST(rst), .bus(bus1), .oDbg_State(dbg1));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    int         proto_viol = 0;
    logic       prev_tck[2] = '{1'b0, 1'b0};
    logic       prev_tcs[2] = '{1'b1, 1'b1};
    logic       prev_rdy[2] = '{1'b1, 1'b1};
    int         rise_n[2];
    int         rise_cyc[2][16];
    logic       tdi_bit[2][16];
    int         tcs_fall_n[2];
    int         tcs_fall_cyc[2][4];
    int         tcs_rise_cyc[2];
    int         rxv_n[2] = '{0, 0};
    int         rxv_cyc[2][4];
    logic [7:0] rxv_data[2][4];
    int         ready_rise_cyc[2];
    int         hi_len[2] = '{0, 0};
    int         last_hi_len[2];
    logic [7:0] resp[2] = '{8'h00, 8'h00};
    logic       cur_tdo[2] = '{1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- monitor + target model ----------------
    task automatic mon(input int id, input logic tck, input logic tcs, input logic tdi,
                       input logic rdy, input logic rxv, input logic [7:0] rxd);
        if (tck && !prev_tck[id]) begin
            if (rise_n[id] < 16) begin
                rise_cyc[id][rise_n[id]] = cyc;
                tdi_bit[id][rise_n[id]]  = tdi;
            end
            cur_tdo[id] = resp[id][rise_n[id] % 8];
            rise_n[id]++;
        end
        if (tcs) cur_tdo[id] = 1'b0;
        if ((tck != prev_tck[id]) && (tcs || prev_tcs[id])) proto_viol++;
        if ((tcs != prev_tcs[id]) && (tck || prev_tck[id])) proto_viol++;
        if (!tcs && prev_tcs[id]) begin
            if (tcs_fall_n[id] < 4) tcs_fall_cyc[id][tcs_fall_n[id]] = cyc;
            tcs_fall_n[id]++;
            last_hi_len[id] = hi_len[id];
        end
        hi_len[id] = tcs ? hi_len[id] + 1 : 0;
        if (tcs && !prev_tcs[id]) tcs_rise_cyc[id] = cyc;
        if (rxv) begin
            if (rxv_n[id] < 4) begin
                rxv_cyc[id][rxv_n[id]]  = cyc;
                rxv_data[id][rxv_n[id]] = rxd;
            end
            rxv_n[id]++;
        end
        if (rdy && !prev_rdy[id]) ready_rise_cyc[id] = cyc;
        prev_tck[id] = tck;
        prev_tcs[id] = tcs;
        prev_rdy[id] = rdy;
    endtask

    always @(negedge clk) begin
        mon(0, bus4.TCK, bus4.TCS, bus4.TDI, bus4.oTx_Ready, bus4.oRx_Valid, bus4.oRx_Data);
        bus4.TDO = cur_tdo[0];
        mon(1, bus1.TCK, bus1.TCS, bus1.TDI, bus1.oTx_Ready, bus1.oRx_Valid, bus1.oRx_Data);
        bus1.TDO = cur_tdo[1];
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input logic [7:0] d);
        if (id == 0) begin
            bus4.iTx_Valid = v;
            bus4.iTx_Data  = d;
        end else begin
            bus1.iTx_Valid = v;
            bus1.iTx_Data  = d;
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? bus4.oTx_Ready : bus1.oTx_Ready;
    endfunction

    function automatic logic [7:0] tdi_byte(input int id, input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = tdi_bit[id][base + i];
        return b;
    endfunction

    task automatic clr(input int id);
        rise_n[id]         = 0;
        tcs_fall_n[id]     = 0;
        rxv_n[id]          = 0;
        tcs_rise_cyc[id]   = -1;
        ready_rise_cyc[id] = -1;
        last_hi_len[id]    = -1;
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        while (!rdy(id) && n < 300) begin
            step();
            n++;
        end
        chk("wait_ready", {31'd0, rdy(id)}, 32'd1);
    endtask

    // Present one byte for exactly the accept cycle, then scramble the data
    // input so a master that fails to latch it sends the wrong bits.
    task automatic send(input int id, input logic [7:0] d, input logic [7:0] r, output int t);
        wait_ready(id);
        clr(id);
        resp[id] = r;
        drive(id, 1'b1, d);
        t = cyc;
        step();
        drive(id, 1'b0, ~d);
    endtask

    task automatic frame_check(input int id, input int t, input logic [7:0] d,
                               input logic [7:0] r, input int c);
        while (cyc < t + 2 + 19 * c) step();
        chk("tcs_fall", tcs_fall_cyc[id][0], t + 1);
        chk("tcs_fall_n", tcs_fall_n[id], 1);
        chk("rise_n", rise_n[id], 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("rise%0d", k), rise_cyc[id][k], t + 1 + c * (1 + 2 * k));
        chk("tdi_byte", {24'd0, tdi_byte(id, 0)}, {24'd0, d});
        chk("rxv_n", rxv_n[id], 1);
        chk("rxv_cyc", rxv_cyc[id][0], t + 1 + 18 * c);
        chk("rxv_data", {24'd0, rxv_data[id][0]}, {24'd0, r});
        chk("tcs_rise", tcs_rise_cyc[id], t + 1 + 18 * c);
        chk("ready_rise", ready_rise_cyc[id], t + 1 + 19 * c);
        chk("rx_hold", {24'd0, (id == 0) ? bus4.oRx_Data : bus1.oRx_Data}, {24'd0, r});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         t, t0, t1, n;
        int         acc_n;
        int         acc_cyc[2];
        logic [7:0] acc_dat[2];
        logic [7:0] d, r, nd;

        rst = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b1, 8'h55);      // valid together with reset must be ignored
        bus4.TDO = 1'b0;
        bus1.TDO = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_tck", {31'd0, bus4.TCK}, 32'd0);
        chk("rst_tcs", {31'd0, bus4.TCS}, 32'd1);
        chk("rst_tdi", {31'd0, bus4.TDI}, 32'd0);
        chk("rst_ready", {31'd0, bus4.oTx_Ready}, 32'd1);
        chk("rst_busy", {31'd0, bus4.oBusy}, 32'd0);
        chk("rst_rxv", {31'd0, bus4.oRx_Valid}, 32'd0);
        chk("rst_rxd", {24'd0, bus4.oRx_Data}, 32'd0);
        chk("rst_tcs1", {31'd0, bus1.TCS}, 32'd1);
        chk("rst_ready1", {31'd0, bus1.oTx_Ready}, 32'd1);
        drive(1, 1'b0, 8'h00);
        rst = 1'b0;
        clr(0);
        clr(1);

        // Idle
        repeat (10) step();
        chk("idle_tck", {31'd0, bus4.TCK}, 32'd0);
        chk("idle_tcs", {31'd0, bus4.TCS}, 32'd1);
        chk("idle_tdi", {31'd0, bus4.TDI}, 32'd0);
        chk("idle_ready", {31'd0, bus4.oTx_Ready}, 32'd1);
        chk("idle_rxv_n", rxv_n[0], 0);
        chk("idle_rxv_n1", rxv_n[1], 0);

        // 0xA5 with TDO tied low
        send(0, 8'hA5, 8'h00, t);
        frame_check(0, t, 8'hA5, 8'h00, 4);

        // Loopback: target answers 0x3C while master sends 0x81
        send(0, 8'h81, 8'h3C, t);
        frame_check(0, t, 8'h81, 8'h3C, 4);

        // Random bytes with random idle gaps
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            r = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) step();
            send(0, d, r, t);
            frame_check(0, t, d, r, 4);
        end

        // Valid held high, data changing every cycle: each frame carries the
        // value present in its accept cycle and the next accept comes exactly
        // at the first ready cycle.
        wait_ready(0);
        clr(0);
        resp[0] = 8'($urandom_range(0, 255));
        acc_n = 0;
        n = 0;
        bus4.iTx_Valid = 1'b1;
        while (acc_n < 2 && n < 400) begin
            nd = 8'($urandom_range(0, 255));
            bus4.iTx_Data = nd;
            if (bus4.oTx_Ready) begin
                acc_cyc[acc_n] = cyc;
                acc_dat[acc_n] = nd;
                acc_n++;
            end
            step();
            n++;
        end
        bus4.iTx_Valid = 1'b0;
        chk("hold_acc_n", acc_n, 2);
        while (cyc < acc_cyc[1] + 2 + 19 * 4) step();
        chk("hold_acc_gap", acc_cyc[1] - acc_cyc[0], 1 + 19 * 4);
        chk("hold_fall_n", tcs_fall_n[0], 2);
        chk("hold_fall1", tcs_fall_cyc[0][1], acc_cyc[1] + 1);
        chk("hold_byte0", {24'd0, tdi_byte(0, 0)}, {24'd0, acc_dat[0]});
        chk("hold_byte1", {24'd0, tdi_byte(0, 8)}, {24'd0, acc_dat[1]});
        chk("hold_rxv_n", rxv_n[0], 2);
        chk("hold_rxd", {24'd0, rxv_data[0][1]}, {24'd0, resp[0]});

        chk("proto_before_rst", proto_viol, 0);

        // Reset after TCK rise 3
        send(0, 8'hC3, 8'h96, t);
        n = 0;
        while (rise_n[0] < 4 && n < 100) begin
            step();
            n++;
        end
        chk("mid_rise3", rise_n[0], 4);
        rst = 1'b1;
        step();
        chk("mid_tcs", {31'd0, bus4.TCS}, 32'd1);
        chk("mid_tck", {31'd0, bus4.TCK}, 32'd0);
        chk("mid_rxd", {24'd0, bus4.oRx_Data}, 32'd0);
        chk("mid_ready", {31'd0, bus4.oTx_Ready}, 32'd1);
        rst = 1'b0;
        repeat (80) step();
        chk("mid_no_rxv", rxv_n[0], 0);
        proto_viol = 0;     // the abort edge itself drops TCK and raises TCS together
        d = 8'($urandom_range(0, 255));
        r = 8'($urandom_range(0, 255));
        send(0, d, r, t);
        frame_check(0, t, d, r, 4);

        // CLK_DIV=1 back-to-back 0xFF then 0x00. TCS goes high at T0+19 and the
        // next frame, accepted at T0+20, pulls it low at T0+21: two cycles high.
        wait_ready(1);
        clr(1);
        resp[1] = 8'($urandom_range(0, 255));
        drive(1, 1'b1, 8'hFF);
        t0 = cyc;
        step();
        drive(1, 1'b1, 8'h00);
        n = 0;
        while (!bus1.oTx_Ready && n < 100) begin
            step();
            n++;
        end
        t1 = cyc;
        step();
        drive(1, 1'b0, 8'h00);
        while (cyc < t1 + 2 + 19) step();
        chk("b2b_acc_gap", t1 - t0, 20);
        chk("b2b_fall0", tcs_fall_cyc[1][0], t0 + 1);
        chk("b2b_fall1", tcs_fall_cyc[1][1], t1 + 1);
        chk("b2b_tcs_hi", last_hi_len[1], 2);
        chk("b2b_rxv_n", rxv_n[1], 2);
        chk("b2b_rxv0", rxv_cyc[1][0], t0 + 19);
        chk("b2b_rxv_gap", rxv_cyc[1][1] - rxv_cyc[1][0], 20);
        chk("b2b_byte0", {24'd0, tdi_byte(1, 0)}, 32'hFF);
        chk("b2b_byte1", {24'd0, tdi_byte(1, 8)}, 32'h00);
        chk("b2b_rxd0", {24'd0, rxv_data[1][0]}, {24'd0, resp[1]});
        chk("b2b_rxd1", {24'd0, rxv_data[1][1]}, {24'd0, resp[1]});

        chk("proto_final", proto_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
